// File: rtl/h2c_traffic_chk.sv
// h2c_traffic_chk: H2C AXI-Stream sink that checks packet length and payload
// pattern, and accumulates packet, beat, error and elapsed-cycle statistics.
module h2c_traffic_chk #(
  parameter int TX_LEN        = 512,
  parameter int MAX_ETH_FRAME = 4096,
  parameter int QID_W         = 11,
  parameter int NUM_Q_MAX     = 8
) (
  input  logic              axi_aclk,
  input  logic              axi_areset,
  input  logic [31:0]       control_reg,
  input  logic [15:0]       txr_size,
  input  logic [31:0]       num_pkt,
  input  logic [QID_W-1:0]  num_queue,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [TX_LEN-1:0] tx_data,
  input  logic              tx_last,
  input  logic [QID_W-1:0]  tx_qid,
  output logic              busy,
  output logic              done,
  output logic [31:0]       pkt_count,
  output logic [31:0]       beat_count,
  output logic [31:0]       err_count,
  output logic              len_err,
  output logic              data_err,
  output logic              qid_err,
  output logic              cfg_err,
  output logic [31:0]       cycles
);
  localparam int LANES = TX_LEN / 32;
  localparam int QI_W  = (NUM_Q_MAX > 1) ? $clog2(NUM_Q_MAX) : 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t           state_q, state_d;
  logic             run_q, ready_q, ready_d;
  logic [15:0]      size_q, size_d;
  logic [10:0]      exp_beats_q, exp_beats_d;
  logic [31:0]      num_pkt_q, num_pkt_d;
  logic [QID_W-1:0] num_queue_q, num_queue_d;
  logic [15:0]      beat_idx_q, beat_idx_d;
  logic [QID_W-1:0] pkt_qid_q, pkt_qid_d;
  logic             pkt_err_q, pkt_err_d;
  logic             started_q, started_d;
  logic [15:0]      seq_q [NUM_Q_MAX];
  logic [15:0]      seq_d [NUM_Q_MAX];
  logic [31:0]      pkt_count_q, pkt_count_d;
  logic [31:0]      beat_count_q, beat_count_d;
  logic [31:0]      err_count_q, err_count_d;
  logic             len_err_q, len_err_d;
  logic             data_err_q, data_err_d;
  logic             qid_err_q, qid_err_d;
  logic             cfg_err_q, cfg_err_d;
  logic [31:0]      cycles_q, cycles_d;

  logic             run, accept;
  logic [16:0]      sz_up;
  logic [10:0]      exp_new, last_idx;
  logic [6:0]       tail_bytes, nbytes;
  logic [QID_W-1:0] cur_qid;
  logic             seq_ign;
  logic [15:0]      cur_seq;
  logic [31:0]      lane_exp;
  logic             pat_bad;
  logic [16:0]      bi1;
  logic             len_bad, qid_bad, data_bad, beat_bad;
  logic             unused_ok;

  assign run       = control_reg[0];
  assign accept    = tx_valid && ready_q;
  assign unused_ok = ^{control_reg[31:2], sz_up[5:0]};

  assign sz_up   = {1'b0, txr_size} + 17'd63;
  assign exp_new = (sz_up[16:6] == 11'd0) ? 11'd1 : sz_up[16:6];

  // Only the bytes up to txr_size in the final beat carry pattern.
  assign last_idx   = exp_beats_q - 11'd1;
  assign tail_bytes = 7'(size_q - {last_idx[9:0], 6'd0});
  always_comb begin
    if ({5'd0, last_idx} > beat_idx_q)       nbytes = 7'd64;
    else if ({5'd0, last_idx} == beat_idx_q) nbytes = tail_bytes;
    else                                     nbytes = 7'd0;
  end

  assign cur_qid = (beat_idx_q == 16'd0) ? tx_qid : pkt_qid_q;
  assign seq_ign = cur_qid >= QID_W'(NUM_Q_MAX);
  assign cur_seq = seq_ign ? 16'd0 : seq_q[cur_qid[QI_W-1:0]];

  always_comb begin
    pat_bad  = 1'b0;
    lane_exp = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_exp = {cur_seq, beat_idx_q[11:0], 4'(k)};
      for (int i = 0; i < 4; i++) begin
        if ((7'(4 * k + i) < nbytes) && (i < 2 || !seq_ign)) begin
          if (tx_data[32*k+8*i +: 8] != lane_exp[8*i +: 8])
            pat_bad = 1'b1;
        end
      end
    end
  end

  assign bi1      = {1'b0, beat_idx_q} + 17'd1;
  assign len_bad  = tx_last ? (bi1 != {6'd0, exp_beats_q})
                            : (bi1 == {6'd0, exp_beats_q});
  assign qid_bad  = tx_qid >= num_queue_q;
  assign data_bad = control_reg[1] && pat_bad;
  assign beat_bad = len_bad || qid_bad || data_bad;

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    exp_beats_d  = exp_beats_q;
    num_pkt_d    = num_pkt_q;
    num_queue_d  = num_queue_q;
    beat_idx_d   = beat_idx_q;
    pkt_qid_d    = pkt_qid_q;
    pkt_err_d    = pkt_err_q;
    started_d    = started_q;
    seq_d        = seq_q;
    pkt_count_d  = pkt_count_q;
    beat_count_d = beat_count_q;
    err_count_d  = err_count_q;
    len_err_d    = len_err_q;
    data_err_d   = data_err_q;
    qid_err_d    = qid_err_q;
    cfg_err_d    = cfg_err_q;
    cycles_d     = cycles_q;
    unique case (state_q)
      IDLE: begin
        if (run && !run_q) begin
          pkt_count_d  = '0;
          beat_count_d = '0;
          err_count_d  = '0;
          cycles_d     = '0;
          started_d    = 1'b0;
          len_err_d    = 1'b0;
          data_err_d   = 1'b0;
          qid_err_d    = 1'b0;
          cfg_err_d    = 1'b0;
          beat_idx_d   = '0;
          pkt_err_d    = 1'b0;
          for (int i = 0; i < NUM_Q_MAX; i++) seq_d[i] = '0;
          size_d      = txr_size;
          num_pkt_d   = num_pkt;
          num_queue_d = num_queue;
          exp_beats_d = exp_new;
          if (txr_size > 16'(MAX_ETH_FRAME)) cfg_err_d = 1'b1;
          else if (num_pkt == 32'd0)         state_d   = DONE;
          else                               state_d   = ACTIVE;
        end
      end
      ACTIVE: begin
        if (accept) beat_count_d = beat_count_q + 32'd1;
        if (!run) begin
          // Abort: any partial packet is dropped uncounted.
          state_d    = IDLE;
          beat_idx_d = '0;
          pkt_err_d  = 1'b0;
        end else begin
          if (started_q) cycles_d = cycles_q + 32'd1;
          else if (accept) begin
            cycles_d  = 32'd1;
            started_d = 1'b1;
          end
          if (accept) begin
            if (len_bad)  len_err_d  = 1'b1;
            if (qid_bad)  qid_err_d  = 1'b1;
            if (data_bad) data_err_d = 1'b1;
            if (beat_idx_q == 16'd0) pkt_qid_d = tx_qid;
            if (tx_last) begin
              pkt_count_d = pkt_count_q + 32'd1;
              if (pkt_err_q || beat_bad) err_count_d = err_count_q + 32'd1;
              if (!seq_ign)
                seq_d[cur_qid[QI_W-1:0]] = cur_seq + 16'd1;
              beat_idx_d = '0;
              pkt_err_d  = 1'b0;
              if (pkt_count_q + 32'd1 == num_pkt_q) state_d = DONE;
            end else begin
              beat_idx_d = beat_idx_q + 16'd1;
              pkt_err_d  = pkt_err_q || beat_bad;
            end
          end
        end
      end
      DONE: begin
        if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ready_d = (state_d == ACTIVE);

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      ready_q      <= 1'b0;
      size_q       <= '0;
      exp_beats_q  <= 11'd1;
      num_pkt_q    <= '0;
      num_queue_q  <= '0;
      beat_idx_q   <= '0;
      pkt_qid_q    <= '0;
      pkt_err_q    <= 1'b0;
      started_q    <= 1'b0;
      for (int i = 0; i < NUM_Q_MAX; i++) seq_q[i] <= '0;
      pkt_count_q  <= '0;
      beat_count_q <= '0;
      err_count_q  <= '0;
      len_err_q    <= 1'b0;
      data_err_q   <= 1'b0;
      qid_err_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run;
      ready_q      <= ready_d;
      size_q       <= size_d;
      exp_beats_q  <= exp_beats_d;
      num_pkt_q    <= num_pkt_d;
      num_queue_q  <= num_queue_d;
      beat_idx_q   <= beat_idx_d;
      pkt_qid_q    <= pkt_qid_d;
      pkt_err_q    <= pkt_err_d;
      started_q    <= started_d;
      seq_q        <= seq_d;
      pkt_count_q  <= pkt_count_d;
      beat_count_q <= beat_count_d;
      err_count_q  <= err_count_d;
      len_err_q    <= len_err_d;
      data_err_q   <= data_err_d;
      qid_err_q    <= qid_err_d;
      cfg_err_q    <= cfg_err_d;
      cycles_q     <= cycles_d;
    end
  end

  assign tx_ready   = ready_q;
  assign busy       = (state_q == ACTIVE);
  assign done       = (state_q == DONE);
  assign pkt_count  = pkt_count_q;
  assign beat_count = beat_count_q;
  assign err_count  = err_count_q;
  assign len_err    = len_err_q;
  assign data_err   = data_err_q;
  assign qid_err    = qid_err_q;
  assign cfg_err    = cfg_err_q;
  assign cycles     = cycles_q;

endmodule

// File: tb/tb_h2c_traffic_chk.sv
// tb_h2c_traffic_chk: scenario tasks with a per-packet scoreboard of
// expected pkt_count/err_count, popped when each packet's last beat lands.
module tb_h2c_traffic_chk;
  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  control_reg;
  logic [15:0]  txr_size;
  logic [31:0]  num_pkt;
  logic [10:0]  num_queue;
  logic         tx_valid;
  logic         tx_ready;
  logic [511:0] tx_data;
  logic         tx_last;
  logic [10:0]  tx_qid;
  logic         busy, done;
  logic [31:0]  pkt_count, beat_count, err_count, cycles;
  logic         len_err, data_err, qid_err, cfg_err;

  h2c_traffic_chk dut (
    .axi_aclk(clk), .axi_areset(rst), .control_reg(control_reg),
    .txr_size(txr_size), .num_pkt(num_pkt), .num_queue(num_queue),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_last(tx_last), .tx_qid(tx_qid), .busy(busy), .done(done),
    .pkt_count(pkt_count), .beat_count(beat_count),
    .err_count(err_count), .len_err(len_err), .data_err(data_err),
    .qid_err(qid_err), .cfg_err(cfg_err), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pkt;
    logic [31:0] err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] tb_seq [8];
  int          tb_size;
  logic [31:0] exp_pkt, exp_err;

  function automatic logic [511:0] mk_beat(input logic [15:0] s, input int b);
    logic [511:0] d;
    d = '0;
    for (int k = 0; k < 16; k++) begin
      if (64 * b + 4 * k >= tb_size) d[32*k +: 32] = 32'hdead_beef;
      else d[32*k +: 32] = {s, 16'(16 * b + k)};
    end
    return d;
  endfunction

  task automatic drive_beat(input logic [511:0] d, input logic last,
                            input logic [10:0] q);
    int   n;
    exp_t e;
    n = 0;
    tx_valid = 1'b1;
    tx_data  = d;
    tx_last  = last;
    tx_qid   = q;
    @(negedge clk);
    while (tx_ready !== 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (tx_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout tx_ready=%b required 1", tx_ready);
      tx_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      if (last && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (pkt_count !== e.pkt || err_count !== e.err) begin
          errors++;
          $display("FAIL pkt_end pkt_count=%0d err_count=%0d required %0d %0d",
                   pkt_count, err_count, e.pkt, e.err);
        end
      end
    end
  endtask

  task automatic send_pkt(input int q, input int nb, input int fb,
                          input int fl, input bit bad, input int gap);
    logic [511:0] d;
    logic [15:0]  s;
    exp_t         e;
    s = (q < 8) ? tb_seq[q] : 16'd0;
    exp_pkt = exp_pkt + 32'd1;
    if (bad) exp_err = exp_err + 32'd1;
    e.pkt = exp_pkt;
    e.err = exp_err;
    sb.push_back(e);
    for (int b = 0; b < nb; b++) begin
      d = mk_beat(s, b);
      if (b == fb) d[32*fl +: 32] = d[32*fl +: 32] ^ 32'h0000_0100;
      drive_beat(d, b == nb - 1, 11'(q));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
    if (q < 8) tb_seq[q] = s + 16'd1;
  endtask

  task automatic start_run(input int size, input int np, input int nq,
                           input bit chk);
    control_reg = 32'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    txr_size  = 16'(size);
    num_pkt   = 32'(np);
    num_queue = 11'(nq);
    tb_size   = size;
    for (int i = 0; i < 8; i++) tb_seq[i] = 16'd0;
    exp_pkt = 32'd0;
    exp_err = 32'd0;
    sb.delete();
    control_reg = {30'd0, chk, 1'b1};
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tx_ready, busy, done, len_err, data_err, qid_err, cfg_err} !== 7'd0) begin
      errors++;
      $display("FAIL reset_flags got %b required 0000000",
               {tx_ready, busy, done, len_err, data_err, qid_err, cfg_err});
    end
    checks++;
    if ({pkt_count, beat_count, err_count, cycles} !== 128'd0) begin
      errors++;
      $display("FAIL reset_counts pkt=%0d beat=%0d err=%0d cyc=%0d required 0",
               pkt_count, beat_count, err_count, cycles);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    start_run(256, 4, 1, 1'b1);
    for (int p = 0; p < 4; p++) send_pkt(0, 4, -1, 0, 1'b0, 0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_done done=%b busy=%b required 1 0", done, busy);
    end
    checks++;
    if (beat_count !== 32'd16) begin
      errors++; $display("FAIL basic_beats got %0d required 16", beat_count);
    end
    checks++;
    if (cycles !== 32'd16) begin
      errors++; $display("FAIL basic_cycles got %0d required 16", cycles);
    end
    checks++;
    if (err_count !== 32'd0 || tx_ready !== 1'b0) begin
      errors++; $display("FAIL basic_err err=%0d ready=%b required 0 0", err_count, tx_ready);
    end
  endtask

  task automatic test_backpressure;
    start_run(256, 4, 1, 1'b1);
    for (int p = 0; p < 4; p++) send_pkt(0, 4, -1, 0, 1'b0, 1);
    checks++;
    if (beat_count !== 32'd16 || pkt_count !== 32'd4) begin
      errors++; $display("FAIL bp_counts beat=%0d pkt=%0d required 16 4", beat_count, pkt_count);
    end
    checks++;
    if (cycles !== 32'd31) begin
      errors++; $display("FAIL bp_cycles got %0d required 31", cycles);
    end
  endtask

  task automatic test_two_queues;
    start_run(100, 7, 2, 1'b1);
    for (int p = 0; p < 6; p++) send_pkt(p % 2, 2, -1, 0, 1'b0, 0);
    checks++;
    if (err_count !== 32'd0 || data_err !== 1'b0 || qid_err !== 1'b0) begin
      errors++; $display("FAIL twoq_clean err=%0d data=%b qid=%b required 0 0 0",
                         err_count, data_err, qid_err);
    end
    send_pkt(2, 2, -1, 0, 1'b1, 0);
    checks++;
    if (qid_err !== 1'b1 || err_count !== 32'd1 || len_err !== 1'b0 || done !== 1'b1) begin
      errors++; $display("FAIL twoq_qid qid=%b err=%0d len=%b done=%b required 1 1 0 1",
                         qid_err, err_count, len_err, done);
    end
  endtask

  task automatic test_len_err;
    start_run(256, 3, 1, 1'b1);
    send_pkt(0, 3, -1, 0, 1'b1, 0);
    checks++;
    if (len_err !== 1'b1) begin
      errors++; $display("FAIL len_short got %b required 1", len_err);
    end
    send_pkt(0, 4, -1, 0, 1'b0, 0);
    send_pkt(0, 6, -1, 0, 1'b1, 0);
    checks++;
    if (err_count !== 32'd2 || pkt_count !== 32'd3 || data_err !== 1'b0) begin
      errors++; $display("FAIL len_long err=%0d pkt=%0d data=%b required 2 3 0",
                         err_count, pkt_count, data_err);
    end
    checks++;
    if (beat_count !== 32'd13 || done !== 1'b1) begin
      errors++; $display("FAIL len_beats beat=%0d done=%b required 13 1", beat_count, done);
    end
  endtask

  task automatic test_data_cfg;
    start_run(256, 2, 1, 1'b1);
    send_pkt(0, 4, 1, 5, 1'b1, 0);
    send_pkt(0, 4, -1, 0, 1'b0, 0);
    checks++;
    if (data_err !== 1'b1 || err_count !== 32'd1) begin
      errors++; $display("FAIL data_on data=%b err=%0d required 1 1", data_err, err_count);
    end
    start_run(256, 2, 1, 1'b0);
    send_pkt(0, 4, 1, 5, 1'b0, 0);
    send_pkt(0, 4, -1, 0, 1'b0, 0);
    checks++;
    if (data_err !== 1'b0 || err_count !== 32'd0 || done !== 1'b1) begin
      errors++; $display("FAIL data_off data=%b err=%0d done=%b required 0 0 1",
                         data_err, err_count, done);
    end
    start_run(5000, 1, 1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
      errors++; $display("FAIL cfg cfg=%b busy=%b ready=%b required 1 0 0",
                         cfg_err, busy, tx_ready);
    end
  endtask

  task automatic test_reset_abort;
    start_run(256, 4, 1, 1'b1);
    drive_beat(mk_beat(16'd0, 0), 1'b0, 11'd0);
    drive_beat(mk_beat(16'd0, 1), 1'b0, 11'd0);
    checks++;
    if (beat_count !== 32'd2 || cycles !== 32'd2) begin
      errors++; $display("FAIL pre_rst beat=%0d cyc=%0d required 2 2", beat_count, cycles);
    end
    #2;
    rst = 1'b1;
    control_reg = 32'd0;
    #1;
    checks++;
    if ({tx_ready, busy, done, beat_count, cycles} !== 67'd0) begin
      errors++; $display("FAIL async_rst ready=%b busy=%b beat=%0d cyc=%0d required 0",
                         tx_ready, busy, beat_count, cycles);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start_run(256, 1, 1, 1'b1);
    send_pkt(0, 4, -1, 0, 1'b0, 0);
    checks++;
    if (done !== 1'b1 || beat_count !== 32'd4 || cycles !== 32'd4 || err_count !== 32'd0) begin
      errors++; $display("FAIL post_rst done=%b beat=%0d cyc=%0d err=%0d required 1 4 4 0",
                         done, beat_count, cycles, err_count);
    end
    start_run(256, 4, 1, 1'b1);
    send_pkt(0, 4, -1, 0, 1'b0, 0);
    drive_beat(mk_beat(16'd1, 0), 1'b0, 11'd0);
    drive_beat(mk_beat(16'd1, 1), 1'b0, 11'd0);
    control_reg = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_ready !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_state busy=%b ready=%b done=%b required 0 0 0",
                         busy, tx_ready, done);
    end
    checks++;
    if (pkt_count !== 32'd1 || beat_count !== 32'd6) begin
      errors++; $display("FAIL abort_hold pkt=%0d beat=%0d required 1 6", pkt_count, beat_count);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    control_reg = 32'd0;
    txr_size    = 16'd0;
    num_pkt     = 32'd0;
    num_queue   = 11'd0;
    tx_valid    = 1'b0;
    tx_data     = '0;
    tx_last     = 1'b0;
    tx_qid      = 11'd0;
    tb_size     = 0;
    exp_pkt     = 32'd0;
    exp_err     = 32'd0;
    for (int i = 0; i < 8; i++) tb_seq[i] = 16'd0;
    test_reset();
    test_basic();
    test_backpressure();
    test_two_queues();
    test_len_err();
    test_data_cfg();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
